// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned INST_W_DEF = 32;
  localparam int unsigned PC_INCR    = 4;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;

  // Force a PC onto a word boundary.
  function automatic logic [ADDR_W_DEF-1:0] align_pc(input logic [ADDR_W_DEF-1:0] pc);
    return {pc[ADDR_W_DEF-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Shift-register FIFO of fetched {pc, inst} pairs; entry 0 is the registered head.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     entries_q [DEPTH];
  fetch_entry_t     entries_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Pop shifts everything toward the head, then a push lands in the first free slot.
  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (pop_i && (count_q != '0)) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          entries_d[i] = entries_q[i+1];
        end
        count_d = count_q - CNT_W'(1);
      end
      if (push_i && (count_d != CNT_W'(DEPTH))) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == count_d) begin
            entries_d[i] = push_data_i;
          end
        end
        count_d = count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign head_o  = entries_q[0];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, talks req/ack to instruction memory, buffers results.
// Optional FETCH_PERF_CNT_EN adds saturating stall/redirect counters.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned INST_W    = INST_W_DEF,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic [ADDR_W-1:0] startpc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] currentpc,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t         state_q;
  logic [ADDR_W-1:0]    fetch_pc_q;
  logic [ADDR_W-1:0]    target_q;

  logic [BUF_CNT_W-1:0] buf_count;
  logic                 buf_valid;
  fetch_entry_t         buf_head;
  fetch_entry_t         push_entry;

  logic                 req_c;
  logic                 ack_c;
  logic                 push_c;
  logic                 flush_c;
  logic                 pop_c;
  logic [ADDR_W-1:0]    target_c;
  logic [ADDR_W-1:0]    pc_next_c;

  assign target_c  = {branch_target[ADDR_W-1:2], 2'b00};
  assign pc_next_c = fetch_pc_q + ADDR_W'(PC_INCR);

  // Request decode uses only registered state so a held request never changes mid-cycle.
  always_comb begin
    req_c   = 1'b0;
    push_c  = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      FETCH: begin
        req_c   = (buf_count != BUF_CNT_W'(BUF_DEPTH));
        flush_c = branch_valid;
        push_c  = req_c && imem_ack && !branch_valid;
      end
      DISCARD: begin
        req_c   = 1'b1;
        flush_c = 1'b1;
      end
      default: begin
        req_c = 1'b0;
      end
    endcase
    ack_c = req_c && imem_ack;
  end

  assign pop_c      = buf_valid && inst_ready;
  assign push_entry = '{pc: ADDR_W_DEF'(fetch_pc_q), inst: INST_W_DEF'(imem_rdata)};

  // A redirect that meets an unacked request must wait out that request in DISCARD.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q    <= BOOT;
      fetch_pc_q <= '0;
      target_q   <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          fetch_pc_q <= {startpc[ADDR_W-1:2], 2'b00};
          state_q    <= FETCH;
        end
        FETCH: begin
          if (branch_valid) begin
            if (req_c && !imem_ack) begin
              target_q <= target_c;
              state_q  <= DISCARD;
            end else begin
              fetch_pc_q <= target_c;
            end
          end else if (ack_c) begin
            fetch_pc_q <= pc_next_c;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            fetch_pc_q <= branch_valid ? target_c : target_q;
            state_q    <= FETCH;
          end else if (branch_valid) begin
            target_q <= target_c;
          end
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (BUF_CNT_W)
  ) u_buf (
    .clk_i       (CLK),
    .rst_ni      (resetl),
    .push_i      (push_c),
    .push_data_i (push_entry),
    .pop_i       (pop_c),
    .flush_i     (flush_c),
    .head_o      (buf_head),
    .valid_o     (buf_valid),
    .count_o     (buf_count)
  );

  assign imem_req   = req_c;
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = buf_valid;
  assign inst_out   = INST_W'(buf_head.inst);
  assign inst_pc    = ADDR_W'(buf_head.pc);
  assign currentpc  = buf_valid ? ADDR_W'(buf_head.pc) : fetch_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Redirects are counted wherever they are honoured, i.e. outside BOOT.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (req_c && !imem_ack && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (branch_valid && (state_q != BOOT) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: vector table, directed corner sequences, random run vs stream model.
module tb_inst_fetch_unit;

  logic        CLK;
  logic        resetl;
  logic [63:0] startpc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_valid;
  logic [63:0] branch_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic [63:0] currentpc;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  inst_fetch_unit #(
    .ADDR_W    (64),
    .INST_W    (32),
    .BUF_DEPTH (2)
  ) dut (
    .CLK            (CLK),
    .resetl         (resetl),
    .startpc        (startpc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .branch_valid   (branch_valid),
    .branch_target  (branch_target),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .currentpc      (currentpc),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int          n_err = 0;
  int          n_chk = 0;
  int          mem_lat = 0;
  bit          mem_rand = 1'b0;
  int          mem_wcnt = 0;
  bit          last_ack = 1'b0;
  logic [63:0] mem_base = 64'd0;
  bit          model_on = 1'b0;
  logic [63:0] exp_pc = 64'd0;
  bit          pend = 1'b0;
  logic [63:0] pend_addr = 64'd0;
  int          pops = 0;

  typedef struct {
    bit          rdy;
    bit          br;
    logic [63:0] tgt;
    bit          req;
    logic [63:0] addr;
    bit          valid;
    logic [63:0] pc;
    logic [63:0] cur;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mkv(input bit rdy, input bit br, input logic [63:0] tgt,
                               input bit req, input logic [63:0] addr, input bit valid,
                               input logic [63:0] pc, input logic [63:0] cur);
    vec_t v;
    v.rdy = rdy; v.br = br; v.tgt = tgt; v.req = req;
    v.addr = addr; v.valid = valid; v.pc = pc; v.cur = cur;
    return v;
  endfunction

  // Memory contents: sequential words counted from mem_base.
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    logic [63:0] d;
    d = (a - mem_base) >> 2;
    return 32'hAA00_0001 + d[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mem_drive();
    bit ack;
    ack = 1'b0;
    if (imem_req) ack = mem_rand ? ($urandom_range(0, 2) != 0) : (mem_wcnt >= mem_lat);
    imem_ack = ack;
    last_ack = ack;
    if (ack) begin
      imem_rdata = inst_of(imem_addr);
      mem_wcnt   = 0;
    end else begin
      imem_rdata = $urandom;
      if (imem_req) mem_wcnt++;
    end
  endtask

  // Called at a negedge: drive inputs and memory, score the cycle, advance one clock.
  task automatic tick(input bit rdy, input bit br, input logic [63:0] tgt);
    inst_ready    = rdy;
    branch_valid  = br;
    branch_target = tgt;
    mem_drive();
    if (model_on) begin
      chk("addr_align", 64'(imem_addr[1:0]), 64'd0);
      chk("currentpc", currentpc, inst_valid ? inst_pc : imem_addr);
      if (br) begin
        exp_pc = {tgt[63:2], 2'b00};
      end else if (inst_valid && rdy) begin
        chk("stream_pc", inst_pc, exp_pc);
        chk("stream_inst", 64'(inst_out), 64'(inst_of(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        pops++;
      end
    end
    pend      = imem_req && !imem_ack;
    pend_addr = imem_addr;
    @(negedge CLK);
    if (model_on && pend) begin
      chk("req_hold", 64'(imem_req), 64'd1);
      chk("addr_hold", imem_addr, pend_addr);
    end
  endtask

  task automatic do_reset(input logic [63:0] spc);
    resetl        = 1'b0;
    inst_ready    = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 64'd0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'd0;
    startpc       = spc;
    mem_wcnt      = 0;
    pend          = 1'b0;
    pops          = 0;
    repeat (2) @(negedge CLK);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst_out), 64'd0);
    chk("rst_pc", inst_pc, 64'd0);
    chk("rst_cur", currentpc, 64'd0);
    chk("rst_perf", {perf_stall_cnt, perf_flush_cnt}, 64'd0);
    resetl = 1'b1;
    exp_pc = {spc[63:2], 2'b00};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    // rdy br tgt | req addr valid pc cur   (startpc=0, zero-wait memory)
    tbl[0]  = mkv(0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   64'h0);
    tbl[1]  = mkv(0, 0, 64'h0,   1, 64'h0,   0, 64'h0,   64'h0);
    tbl[2]  = mkv(0, 0, 64'h0,   1, 64'h4,   1, 64'h0,   64'h0);
    tbl[3]  = mkv(0, 0, 64'h0,   0, 64'h8,   1, 64'h0,   64'h0);
    tbl[4]  = mkv(1, 0, 64'h0,   0, 64'h8,   1, 64'h0,   64'h0);
    tbl[5]  = mkv(1, 0, 64'h0,   1, 64'h8,   1, 64'h4,   64'h4);
    tbl[6]  = mkv(0, 0, 64'h0,   1, 64'hC,   1, 64'h8,   64'h8);
    tbl[7]  = mkv(1, 0, 64'h0,   0, 64'h10,  1, 64'h8,   64'h8);
    tbl[8]  = mkv(1, 1, 64'h203, 1, 64'h10,  1, 64'hC,   64'hC);
    tbl[9]  = mkv(1, 0, 64'h0,   1, 64'h200, 0, 64'h0,   64'h200);
    tbl[10] = mkv(1, 0, 64'h0,   1, 64'h204, 1, 64'h200, 64'h200);
    tbl[11] = mkv(0, 0, 64'h0,   1, 64'h208, 1, 64'h204, 64'h204);
    tbl[12] = mkv(0, 0, 64'h0,   0, 64'h20C, 1, 64'h204, 64'h204);

    resetl = 1'b0;
    model_on = 1'b1;

    // Backpressure, in-order drain, and redirect coinciding with an ack.
    mem_base = 64'd0; mem_lat = 0; mem_rand = 1'b0;
    do_reset(64'd0);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d_req", i), 64'(imem_req), 64'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 64'(inst_valid), 64'(tbl[i].valid));
      chk($sformatf("tbl%0d_cur", i), currentpc, tbl[i].cur);
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_inst", i), 64'(inst_out), 64'(inst_of(tbl[i].pc)));
      end
      tick(tbl[i].rdy, tbl[i].br, tbl[i].tgt);
    end

    // Boot from 0x40 with zero-wait memory.
    mem_base = 64'h40;
    do_reset(64'h40);
    chk("boot_req0", 64'(imem_req), 64'd0);
    tick(1, 0, 64'd0);
    chk("boot_addr", imem_addr, 64'h40);
    chk("boot_req1", 64'(imem_req), 64'd1);
    tick(1, 0, 64'd0);
    chk("boot_valid", 64'(inst_valid), 64'd1);
    chk("boot_pc0", inst_pc, 64'h40);
    chk("boot_inst0", 64'(inst_out), 64'hAA00_0001);
    chk("boot_cur", currentpc, 64'h40);
    tick(1, 0, 64'd0);
    chk("boot_pc1", inst_pc, 64'h44);
    chk("boot_inst1", 64'(inst_out), 64'hAA00_0002);

    // Wrap of the fetch PC past the top of the address space.
    mem_base = 64'hFFFF_FFFF_FFFF_FFFC;
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    tick(1, 0, 64'd0);
    chk("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1, 0, 64'd0);
    chk("wrap_addr1", imem_addr, 64'h0);
    chk("wrap_pc0", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1, 0, 64'd0);
    chk("wrap_pc1", inst_pc, 64'h0);
    chk("wrap_inst1", 64'(inst_out), 64'hAA00_0002);

    // Redirect while a slow request is outstanding.
    begin
      bit found;
      bit acked;
      int n;
      mem_base = 64'd0; mem_lat = 3;
      do_reset(64'd0);
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
        if (imem_req && imem_addr == 64'h8) found = 1'b1;
        else tick(1, 0, 64'd0);
      end
      chk("pend_find_req8", 64'(found), 64'd1);
      tick(1, 1, 64'h103);
      acked = last_ack;
      n = 0;
      while (!acked && n < 10) begin
        chk("pend_hold_req", 64'(imem_req), 64'd1);
        chk("pend_hold_addr", imem_addr, 64'h8);
        tick(1, 0, 64'd0);
        acked = last_ack;
        n++;
      end
      chk("pend_ack_seen", 64'(acked), 64'd1);
      chk("pend_next_addr", imem_addr, 64'h100);
      chk("pend_next_req", 64'(imem_req), 64'd1);
      n = 0;
      while (!inst_valid && n < 20) begin
        tick(1, 0, 64'd0);
        n++;
      end
      chk("pend_first_valid", 64'(inst_valid), 64'd1);
      chk("pend_first_pc", inst_pc, 64'h100);
    end

    // Two redirects, fill the buffer, then reset asynchronously mid-operation.
    mem_base = 64'd0; mem_lat = 0;
    do_reset(64'd0);
    tick(0, 0, 64'd0);
    tick(0, 1, 64'h80);
    tick(0, 1, 64'h80);
    tick(0, 0, 64'd0);
    tick(0, 0, 64'd0);
    chk("mid_valid", 64'(inst_valid), 64'd1);
    chk("mid_full_req", 64'(imem_req), 64'd0);
    chk("mid_pc", inst_pc, 64'h80);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_perf_flush", 64'(perf_flush_cnt), 64'd2);
    chk("mid_perf_stall", 64'(perf_stall_cnt), 64'd0);
`else
    chk("mid_perf_flush", 64'(perf_flush_cnt), 64'd0);
    chk("mid_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    #2;
    resetl = 1'b0;
    #1;
    chk("async_valid", 64'(inst_valid), 64'd0);
    chk("async_req", 64'(imem_req), 64'd0);
    chk("async_cur", currentpc, 64'd0);
    chk("async_perf", 64'(perf_flush_cnt), 64'd0);

    // Random traffic against the stream model.
    for (int t = 0; t < 4; t++) begin
      logic [63:0] spc;
      spc      = {$urandom, $urandom};
      mem_base = 64'd0;
      mem_lat  = t;
      mem_rand = (t % 2) == 1;
      do_reset(spc);
      for (int c = 0; c < 600; c++) begin
        bit          rdy;
        bit          br;
        logic [63:0] tgt;
        rdy = ($urandom_range(0, 3) != 0);
        br  = (c > 0) && ($urandom_range(0, 19) == 0);
        tgt = {$urandom, $urandom};
        tick(rdy, br, tgt);
      end
      for (int c = 0; c < 8; c++) tick(1, 0, 64'd0);
      chk($sformatf("rand%0d_progress", t), 64'(pops > 20), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
